// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned CNT_W    = $clog2(XLEN_DEF) + 1;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } md_state_t;

endpackage

// File: rtl/muldiv_addsub.sv
// Combinational add/subtract shared by the shift-add and shift-subtract steps.
module muldiv_addsub
  import muldiv_pkg::*;
#(
  parameter int unsigned W = XLEN_DEF + 1
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sub,
  output logic [W-1:0] o_sum
);

  always_comb begin
    o_sum = i_sub ? (i_a - i_b) : (i_a + i_b);
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide: one shift-add or restoring shift-subtract step per cycle.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned   CW   = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  md_state_t       r_state;
  md_op_t          r_op;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_hi, r_lo, r_b, r_res;
  logic            r_neg, r_busy, r_done;

  md_op_t            w_op;
  logic              w_a_sgn, w_b_sgn, w_div0, w_ovf, w_neg, w_is_div;
  logic [XLEN-1:0]   w_a_mag, w_b_mag, w_byp_res;
  logic [XLEN:0]     w_add_a, w_add_b, w_sum;
  logic [XLEN-1:0]   w_hi_nxt, w_lo_nxt, w_fin_res;
  logic [2*XLEN-1:0] w_prod, w_prod_s;

  // Accept-time decode: operand magnitudes, result sign and the bypass cases.
  always_comb begin
    w_op      = md_op_t'(funct3);
    w_a_sgn   = op_a[XLEN-1] & (w_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    w_b_sgn   = op_b[XLEN-1] & (w_op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
    w_a_mag   = w_a_sgn ? -op_a : op_a;
    w_b_mag   = w_b_sgn ? -op_b : op_b;
    w_neg     = (w_op == OP_REM) ? w_a_sgn : (w_a_sgn ^ w_b_sgn);
    w_div0    = funct3[2] & (op_b == '0);
    w_ovf     = (w_op inside {OP_DIV, OP_REM}) && (op_a == {1'b1, {(XLEN-1){1'b0}}})
                && (op_b == '1);
    w_byp_res = '0;
    if (w_div0)
      w_byp_res = funct3[1] ? op_a : '1;
    else if (w_ovf)
      w_byp_res = funct3[1] ? '0 : op_a;
  end

  // r_hi holds the partial product / remainder, r_lo the multiplier / quotient.
  always_comb begin
    w_is_div = r_op[2];
    w_add_a  = w_is_div ? {r_hi, r_lo[XLEN-1]} : {1'b0, r_hi};
    w_add_b  = (w_is_div || r_lo[0]) ? {1'b0, r_b} : '0;
  end

  muldiv_addsub #(.W(XLEN + 1)) u_addsub (
    .i_a   (w_add_a),
    .i_b   (w_add_b),
    .i_sub (w_is_div),
    .o_sum (w_sum)
  );

  always_comb begin
    if (w_is_div) begin
      if (!w_sum[XLEN]) begin
        w_hi_nxt = w_sum[XLEN-1:0];
        w_lo_nxt = {r_lo[XLEN-2:0], 1'b1};
      end else begin
        w_hi_nxt = {r_hi[XLEN-2:0], r_lo[XLEN-1]};
        w_lo_nxt = {r_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      w_hi_nxt = w_sum[XLEN:1];
      w_lo_nxt = {w_sum[0], r_lo[XLEN-1:1]};
    end
    w_prod   = {w_hi_nxt, w_lo_nxt};
    w_prod_s = r_neg ? -w_prod : w_prod;
    case (r_op)
      OP_MUL:                        w_fin_res = w_prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  w_fin_res = w_prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               w_fin_res = r_neg ? -w_lo_nxt : w_lo_nxt;
      OP_REM, OP_REMU:               w_fin_res = r_neg ? -w_hi_nxt : w_hi_nxt;
      default:                       w_fin_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_op    <= OP_MUL;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_neg   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && !kill) begin
            r_op   <= w_op;
            r_cnt  <= '0;
            r_neg  <= w_neg;
            r_hi   <= '0;
            r_lo   <= w_a_mag;
            r_b    <= w_b_mag;
            r_busy <= 1'b1;
            if (w_div0 || w_ovf) begin
              r_res   <= w_byp_res;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (kill) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == LAST) begin
              r_res   <= w_fin_res;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_res;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: driver pushes expected results, monitor pops on done.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int XLEN = 32;
  localparam int LAT  = 32;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, kill = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0, op_b = '0;
  logic        busy, done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0, errors = 0;
  int          cyc = 0, dones = 0, expected_dones = 0;
  logic [31:0] last_res = '0;

  muldiv_sequencer #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .kill   (kill),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  // Reference arithmetic straight from the RV32M definitions, 64-bit wide.
  function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa, sbv, sp;
    logic [63:0]        ua, ub, up;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    case (f)
      3'b000: begin up = ua * ub; return up[31:0]; end
      3'b001: begin sp = sa * sbv; return sp[63:32]; end
      3'b010: begin sp = sa * $signed(ub); return sp[63:32]; end
      3'b011: begin up = ua * ub; return up[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        sp = sa / sbv; return sp[31:0];
      end
      3'b101: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        sp = sa % sbv; return sp[31:0];
      end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic bit is_bypass(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 6))
      0:       v = 32'h0;
      1:       v = 32'h1;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'h8000_0000;
      4:       v = $urandom_range(0, 40);
      5:       v = -32'($urandom_range(1, 40));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Monitor: pops on every done, checks value and cycle, and that result holds otherwise.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (done) begin
        dones++;
        if (sbq.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("result", result, e.res);
          last_res = e.res;
        end
      end else begin
        if (sbq.size() > 0 && cyc > sbq[0].cyc) begin
          chk("missing_done", 32'(cyc), 32'(sbq[0].cyc));
          void'(sbq.pop_front());
        end
        chk("result_hold", result, last_res);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic drive_start(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                             input bit expect_done);
    exp_t e;
    funct3 = f;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
    if (expect_done) begin
      e.res = ref_md(f, a, b);
      e.cyc = cyc + 1 + (is_bypass(f, a, b) ? 0 : LAT);
      sbq.push_back(e);
      expected_dones++;
    end
    tick();
    start = 1'b0;
  endtask

  // Waits out the operation while throwing random start pulses that must be ignored.
  task automatic drain();
    int n = 0;
    while (busy && n < 200) begin
      if ($urandom_range(0, 3) == 0) begin
        start  = 1'b1;
        funct3 = 3'($urandom_range(0, 7));
        op_a   = pick();
        op_b   = pick();
      end
      tick();
      start = 1'b0;
      n++;
    end
    if (busy) chk("drain_timeout", 32'(busy), 32'd0);
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    wait_idle();
    drive_start(f, a, b, 1'b1);
    chk("busy_after_accept", 32'(busy), 32'd1);
    drain();
  endtask

  initial begin
    int n;
    #12;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", result, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    run_op(3'b000, 32'd7, 32'hFFFF_FFFD);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'b100, -32'd20, 32'd3);
    run_op(3'b110, -32'd20, 32'd3);
    run_op(3'b101, 32'd100, 32'd0);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'b111, 32'd55, 32'd0);

    // Kill mid-divide: no done, result holds, next start accepted at once.
    wait_idle();
    drive_start(3'b100, 32'd1000, 32'd7, 1'b0);
    repeat (9) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("kill_busy", 32'(busy), 32'd0);
    chk("kill_done", 32'(done), 32'd0);
    drive_start(3'b101, 32'd1000, 32'd7, 1'b1);
    chk("start_after_kill", 32'(busy), 32'd1);
    drain();

    // Kill and start together in IDLE: kill wins.
    wait_idle();
    funct3 = 3'b000; op_a = 32'd3; op_b = 32'd4;
    start = 1'b1; kill = 1'b1;
    tick();
    start = 1'b0; kill = 1'b0;
    chk("kill_start_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 50; i++) run_op(3'($urandom_range(0, 7)), pick(), pick());

    // Asynchronous reset in the middle of a multiply.
    wait_idle();
    drive_start(3'b000, pick(), pick(), 1'b1);
    repeat (4) tick();
    #2 rst_n = 1'b0;
    expected_dones -= sbq.size();
    sbq.delete();
    last_res = '0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    chk("async_rst_result", result, 32'd0);
    tick();
    #1 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) run_op(3'($urandom_range(0, 7)), pick(), pick());

    n = 0;
    while (sbq.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    repeat (3) tick();
    chk("done_count", 32'(dones), 32'(expected_dones));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-005 The block SHALL have port kill, input, 1 bit: pipeline flush; aborts any operation in progress.
REQ-006 The block SHALL have port funct3, input, 3 bits: the RV32M operation select.
REQ-007 The block SHALL have ports op_a and op_b, input, XLEN bits each: the dividend/multiplicand and the divisor/multiplier.
REQ-008 The block SHALL have port busy, output, 1 bit: high in every state except IDLE; the hazard logic uses it to stall.
REQ-009 The block SHALL have port done, output, 1 bit: a single-cycle pulse marking result valid.
REQ-010 The block SHALL have port result, output, XLEN bits: the operation result.

Function
REQ-011 funct3 SHALL decode as: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-012 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-013 IDLE SHALL go to BUSY on an edge with start=1 and kill=0, latching funct3, op_a and op_b and clearing the iteration counter.
REQ-014 BUSY SHALL perform one shift-add step (multiply) or one restoring shift-subtract step (divide) per cycle, for exactly XLEN cycles.
REQ-015 BUSY SHALL go to DONE on the edge that completes iteration XLEN, using a counter of width log2(XLEN)+1 bits with no wrap-around.
REQ-016 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-017 With a normal operation accepted at edge k, done SHALL be high in the cycle after edge k+XLEN (latency XLEN+1 cycles).
REQ-018 Signed operands SHALL be converted to magnitudes at accept time, and the sign of the result SHALL be fixed up in the final iteration.
REQ-019 The signedness rules SHALL be: MULHSU treats op_a as signed and op_b as unsigned; a REM result takes the sign of the dividend.
REQ-020 MUL SHALL return the low XLEN bits of the 2*XLEN-bit product; MULH, MULHSU and MULHU SHALL return the high XLEN bits.
REQ-021 Divide by zero SHALL bypass BUSY and go IDLE to DONE: DIV/DIVU give all ones, REM/REMU give op_a.
REQ-022 Signed overflow (DIV/REM with op_a = 2^(XLEN-1) and op_b = all ones) SHALL bypass BUSY: DIV gives op_a, REM gives 0.
REQ-023 start while busy=1 SHALL be ignored, with no queueing.
REQ-024 kill=1 in BUSY or DONE SHALL force IDLE on the next edge; done SHALL NOT pulse after that edge; result SHALL keep its previous value.
REQ-025 If kill=1 and start=1 arrive together in IDLE, kill SHALL win and the state SHALL remain IDLE.
REQ-026 result SHALL change only on the edge entering DONE and SHALL hold stable until the next DONE.
REQ-027 done and start in the same cycle SHALL NOT be accepted; a new start is sampled only in the following IDLE cycle.

Reset
REQ-028 Asserting rst_n=0 SHALL immediately force state to IDLE, with busy=0, done=0, result=0 and the counter and operand registers at 0.
REQ-029 Reset during BUSY SHALL abandon the operation, and no done SHALL follow.
REQ-030 Deassertion of reset SHALL take effect at the first clk edge after rst_n returns to 1.

Structure
REQ-031 Package muldiv_pkg SHALL hold: XLEN default, the md_op_t enum (the eight funct3 codes), the md_state_t enum (IDLE, BUSY, DONE) and the counter width constant.
REQ-032 The block SHALL contain one sub-module, muldiv_addsub: an (XLEN+1)-bit combinational add/subtract shared by the multiply and divide steps.
REQ-033 All remaining logic (FSM, counter, operand/accumulator registers, sign fix-up) SHALL live in muldiv_sequencer.

Verification
REQ-034 MUL: op_a=7, op_b=-3 (0xFFFFFFFD), start at cycle 0 -> busy at cycle 1, done at cycle 33, result 0xFFFFFFEB.
REQ-035 MULHU: 0xFFFFFFFF * 0xFFFFFFFF -> result 0xFFFFFFFE; MULH with the same operands -> result 0x00000000.
REQ-036 DIV: -20 / 3 -> result 0xFFFFFFFA (-6); REM with the same operands -> result 0xFFFFFFFE (-2), with latency 33 cycles.
REQ-037 DIVU 100/0 -> done at cycle 1 with result 0xFFFFFFFF; REM 0x80000000 / 0xFFFFFFFF -> done at cycle 1 with result 0.
REQ-038 Start DIV, then kill at cycle 10 -> IDLE at cycle 11, no done pulse, result unchanged; a start at cycle 11 is accepted.
REQ-039 Start MUL, drive rst_n=0 asynchronously mid-cycle at cycle 5 -> busy falls immediately; start pulses during BUSY are ignored (bench checks that exactly one done occurs per accepted start).
